// File: rtl/wdt_pkg.sv
// ---------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the multi-channel watchdog:
//   - wdt_cause_e   : 2-bit trip cause code reported per channel
//   - wdt_params_ok : elaboration-time sanity check of the parameter set
// ---------------------------------------------------------------------------
package wdt_pkg;

    typedef enum logic [1:0] {
        WDT_CAUSE_NONE    = 2'd0,
        WDT_CAUSE_TIMEOUT = 2'd1,
        WDT_CAUSE_EARLY   = 2'd2,
        WDT_CAUSE_FORCED  = 2'd3
    } wdt_cause_e;

    // Returns 1 when the parameter combination is usable.
    function automatic bit wdt_params_ok(
        input int num_ch,
        input int cnt_w,
        input int timeout_cyc,
        input int warn_cyc,
        input int win_min_cyc,
        input int rst_pulse
    );
        bit ok;
        ok = (num_ch >= 1) && (num_ch <= 16);
        ok = ok && (cnt_w >= 1) && (cnt_w <= 32);
        ok = ok && (timeout_cyc >= 1);
        // timeout must be representable in the counter (ints >= 31 bits always fit)
        ok = ok && ((cnt_w >= 31) || (timeout_cyc < (1 << cnt_w)));
        ok = ok && (warn_cyc >= 0) && (warn_cyc < timeout_cyc);
        ok = ok && (win_min_cyc >= 0) && (win_min_cyc <= timeout_cyc);
        ok = ok && (rst_pulse >= 1);
        return ok;
    endfunction

endpackage

// File: rtl/wdt_channel.sv
// ---------------------------------------------------------------------------
// wdt_channel
// One watchdog channel: idle counter, warning flag, sticky trip and cause.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : low holds the channel idle and cleared
//   heartbeat     : kick, level sampled every clock
//   window_en     : flag heartbeats arriving while counter < WIN_MIN_CYC
//   force_trip    : trip this channel (cause FORCED) if not already tripped
//   clear_trip    : clear trip, cause and counter
//   warning       : registered, counter >= WARN_CYC and not tripped
//   triggered     : registered sticky trip flag
//   trig_next     : next-state value of triggered (lets the top register
//                   any_triggered in the same cycle as triggered)
//   cause         : registered trip cause (wdt_cause_e encoding)
// ---------------------------------------------------------------------------
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int WARN_CYC    = 750,
    parameter int WIN_MIN_CYC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       heartbeat,
    input  logic       window_en,
    input  logic       force_trip,
    input  logic       clear_trip,
    output logic       warning,
    output logic       triggered,
    output logic       trig_next,
    output logic [1:0] cause
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] WARN_V    = CNT_W'(WARN_CYC);
    localparam logic [CNT_W-1:0] WIN_MIN_V = CNT_W'(WIN_MIN_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    wdt_cause_e       cause_q;
    wdt_cause_e       cause_d;
    logic             trig_q;
    logic             trig_d;
    logic             warn_q;
    logic             warn_d;

    // Next-state logic, branches ordered by priority (rst handled in the flop).
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        cause_d = cause_q;
        if (!enable) begin
            cnt_d   = '0;
            trig_d  = 1'b0;
            cause_d = WDT_CAUSE_NONE;
        end else if (clear_trip) begin
            cnt_d   = '0;
            trig_d  = 1'b0;
            cause_d = WDT_CAUSE_NONE;
        end else if (trig_q) begin
            // tripped: counter frozen, heartbeats ignored
        end else if (force_trip) begin
            trig_d  = 1'b1;
            cause_d = WDT_CAUSE_FORCED;
        end else if (window_en && heartbeat && (cnt_q < WIN_MIN_V)) begin
            trig_d  = 1'b1;
            cause_d = WDT_CAUSE_EARLY;
        end else if (heartbeat) begin
            cnt_d = '0;
        end else begin
            // counting stops at TIMEOUT_V because the trip freezes it: no wrap
            cnt_d = cnt_inc;
            if (cnt_inc == TIMEOUT_V) begin
                trig_d  = 1'b1;
                cause_d = WDT_CAUSE_TIMEOUT;
            end
        end
        // warning is never shown together with (or after) a trip
        warn_d = enable && !trig_d && (cnt_d >= WARN_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            cause_q <= WDT_CAUSE_NONE;
            warn_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            cause_q <= cause_d;
            warn_q  <= warn_d;
        end
    end

    assign warning   = warn_q;
    assign triggered = trig_q;
    assign trig_next = trig_d;
    assign cause     = cause_q;

endmodule

// File: rtl/wdt_multi_channel.sv
// ---------------------------------------------------------------------------
// wdt_multi_channel
// Parametrised multi-channel watchdog. Each channel watches one heartbeat
// source; any new trip raises a fixed-length system reset request.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable         : [NUM_CH] per-channel enable
//   heartbeat      : [NUM_CH] per-channel kick
//   window_en      : [NUM_CH] per-channel early-heartbeat check
//   force_reset    : trips every enabled, untripped channel (cause FORCED)
//   clear_trip     : [NUM_CH] clears latched trip/cause of that channel
//   warning        : [NUM_CH] registered warning flags
//   triggered      : [NUM_CH] registered sticky trip flags
//   cause          : [2*NUM_CH] trip cause, channel i at [2i+1:2i]
//   any_triggered  : registered OR of triggered
//   sys_rst_req    : RST_PULSE-cycle pulse after any new trip
// ---------------------------------------------------------------------------
module wdt_multi_channel
    import wdt_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int WARN_CYC    = 750,
    parameter int WIN_MIN_CYC = 100,
    parameter int RST_PULSE   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   enable,
    input  logic [NUM_CH-1:0]   heartbeat,
    input  logic [NUM_CH-1:0]   window_en,
    input  logic                force_reset,
    input  logic [NUM_CH-1:0]   clear_trip,
    output logic [NUM_CH-1:0]   warning,
    output logic [NUM_CH-1:0]   triggered,
    output logic [2*NUM_CH-1:0] cause,
    output logic                any_triggered,
    output logic                sys_rst_req
);

    localparam bit PARAMS_OK = wdt_params_ok(NUM_CH, CNT_W, TIMEOUT_CYC,
                                             WARN_CYC, WIN_MIN_CYC, RST_PULSE);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("wdt_multi_channel: parameter set out of range");
        end
    endgenerate

    // Pulse counter holds the remaining cycles after the current one.
    localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE - 1);

    logic [NUM_CH-1:0] trig_next_vec;
    logic [NUM_CH-1:0] trig_prev;
    logic [PW-1:0]     pulse_cnt;
    logic              new_trip;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wdt_channel #(
            .CNT_W      (CNT_W),
            .TIMEOUT_CYC(TIMEOUT_CYC),
            .WARN_CYC   (WARN_CYC),
            .WIN_MIN_CYC(WIN_MIN_CYC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable[i]),
            .heartbeat (heartbeat[i]),
            .window_en (window_en[i]),
            .force_trip(force_reset),
            .clear_trip(clear_trip[i]),
            .warning   (warning[i]),
            .triggered (triggered[i]),
            .trig_next (trig_next_vec[i]),
            .cause     (cause[2*i +: 2])
        );
    end

    // A 0->1 on any registered trip flag (re)starts the full-length pulse.
    assign new_trip = |(triggered & ~trig_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_prev     <= '0;
            any_triggered <= 1'b0;
            pulse_cnt     <= '0;
            sys_rst_req   <= 1'b0;
        end else begin
            trig_prev     <= triggered;
            any_triggered <= |trig_next_vec;
            if (new_trip) begin
                pulse_cnt   <= PULSE_LOAD;
                sys_rst_req <= 1'b1;
            end else if (pulse_cnt != '0) begin
                pulse_cnt   <= pulse_cnt - 1'b1;
                sys_rst_req <= 1'b1;
            end else begin
                sys_rst_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wdt_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_wdt_multi_channel
// Directed bench for wdt_multi_channel (NUM_CH=2, TIMEOUT=16, WARN=12,
// WIN_MIN=4, RST_PULSE=8). A behavioural reference model predicts every
// output each cycle; predictions are queued and compared after the edge.
// Directed checks against fixed numbers cover the key timing points.
// ---------------------------------------------------------------------------
module tb_wdt_multi_channel;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int WARN_CYC    = 12;
    localparam int WIN_MIN_CYC = 4;
    localparam int RST_PULSE   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_CH-1:0]   enable;
    logic [NUM_CH-1:0]   heartbeat;
    logic [NUM_CH-1:0]   window_en;
    logic                force_reset;
    logic [NUM_CH-1:0]   clear_trip;
    logic [NUM_CH-1:0]   warning;
    logic [NUM_CH-1:0]   triggered;
    logic [2*NUM_CH-1:0] cause;
    logic                any_triggered;
    logic                sys_rst_req;

    int vectors     = 0;
    int miscompares = 0;

    wdt_multi_channel #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .WARN_CYC   (WARN_CYC),
        .WIN_MIN_CYC(WIN_MIN_CYC),
        .RST_PULSE  (RST_PULSE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .heartbeat    (heartbeat),
        .window_en    (window_en),
        .force_reset  (force_reset),
        .clear_trip   (clear_trip),
        .warning      (warning),
        .triggered    (triggered),
        .cause        (cause),
        .any_triggered(any_triggered),
        .sys_rst_req  (sys_rst_req)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    int       m_cnt   [NUM_CH];
    bit       m_trig  [NUM_CH];
    bit       m_warn  [NUM_CH];
    int       m_cause [NUM_CH];
    bit       m_prev  [NUM_CH];
    int       m_pulse;
    logic [9:0] exp_q[$];

    task automatic model_step();
        bit rise;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[i] = 0; m_trig[i] = 0; m_warn[i] = 0; m_cause[i] = 0; m_prev[i] = 0;
            end
            m_pulse = 0;
            return;
        end
        // pulse logic sees the trip flags as they were before this edge
        rise = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_trig[i] && !m_prev[i]) rise = 1;
            m_prev[i] = m_trig[i];
        end
        if (rise) m_pulse = RST_PULSE;
        else if (m_pulse > 0) m_pulse--;
        for (int i = 0; i < NUM_CH; i++) begin
            m_warn[i] = 0;
            if (!enable[i] || clear_trip[i]) begin
                m_cnt[i] = 0; m_trig[i] = 0; m_cause[i] = 0;
            end else if (m_trig[i]) begin
                // frozen
            end else if (force_reset) begin
                m_trig[i] = 1; m_cause[i] = 3;
            end else if (window_en[i] && heartbeat[i] && m_cnt[i] < WIN_MIN_CYC) begin
                m_trig[i] = 1; m_cause[i] = 2;
            end else if (heartbeat[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == TIMEOUT_CYC) begin
                    m_trig[i] = 1; m_cause[i] = 1;
                end else begin
                    m_warn[i] = (m_cnt[i] >= WARN_CYC);
                end
            end
        end
    endtask

    function automatic logic [9:0] model_vec();
        logic [9:0] v;
        v[9]   = m_warn[1];
        v[8]   = m_warn[0];
        v[7]   = m_trig[1];
        v[6]   = m_trig[0];
        v[5:4] = 2'(m_cause[1]);
        v[3:2] = 2'(m_cause[0]);
        v[1]   = m_trig[0] | m_trig[1];
        v[0]   = (m_pulse > 0);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model predicts at the edge, DUT output compared 1 time unit later.
    task automatic step();
        logic [9:0] exp_v;
        @(posedge clk);
        model_step();
        exp_q.push_back(model_vec());
        #1;
        exp_v = exp_q.pop_front();
        check("scoreboard", {22'd0, warning, triggered, cause, any_triggered, sys_rst_req},
              {22'd0, exp_v});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int wrise;
        int trise;
        int pulses;

        rst = 1'b1; enable = '0; heartbeat = '0; window_en = '0;
        force_reset = 1'b0; clear_trip = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_trig[i] = 0; m_warn[i] = 0; m_cause[i] = 0; m_prev[i] = 0;
        end
        m_pulse = 0;

        // ---- reset ----
        steps(2);
        check("reset_outputs", {22'd0, warning, triggered, cause, any_triggered, sys_rst_req}, 32'd0);

        // ---- timeout on channel 0 ----
        rst = 1'b0; enable = 2'b01;
        wrise = -1; trise = -1; pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (warning[0] && wrise < 0) wrise = k;
            if (triggered[0] && trise < 0) trise = k;
            if (sys_rst_req) pulses++;
        end
        check("warn_rise_cycle", wrise, 12);
        check("trip_cycle", trise, 16);
        check("timeout_cause", {30'd0, cause[1:0]}, 32'd1);
        check("timeout_pulse_len", pulses, 8);
        check("ch1_idle", {31'd0, triggered[1]}, 32'd0);

        // ---- heartbeat at the boundary ----
        clear_trip = 2'b01; step(); clear_trip = '0;
        steps(15);
        check("warn_before_hb", {31'd0, warning[0]}, 32'd1);
        heartbeat = 2'b01; step(); heartbeat = '0;
        check("hb_no_trip", {31'd0, triggered[0]}, 32'd0);
        check("hb_warn_drop", {31'd0, warning[0]}, 32'd0);
        steps(15);
        check("hb_counter_restart", {31'd0, triggered[0]}, 32'd0);
        step();
        check("hb_full_timeout", {31'd0, triggered[0]}, 32'd1);
        steps(10);

        // ---- early fault on channel 1 ----
        clear_trip = 2'b01; enable = 2'b11; window_en = 2'b10; step(); clear_trip = '0;
        step();
        heartbeat = 2'b10; step(); heartbeat = '0;
        check("early_trip", {31'd0, triggered[1]}, 32'd1);
        check("early_cause", {30'd0, cause[3:2]}, 32'd2);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sys_rst_req) pulses++;
        end
        check("early_pulse_len", pulses, 8);
        heartbeat = 2'b10; step(); heartbeat = '0;
        check("early_hb_ignored", {30'd0, triggered[1], cause[3]}, {30'd0, 2'b11});

        // ---- force and clear ----
        clear_trip = 2'b11; step(); clear_trip = '0;
        force_reset = 1'b1; step(); force_reset = 1'b0;
        check("force_both", {30'd0, triggered}, 32'd3);
        check("force_cause", {28'd0, cause}, 32'hF);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sys_rst_req) pulses++;
        end
        check("force_pulse_len", pulses, 8);
        clear_trip = 2'b01; force_reset = 1'b1; step();
        clear_trip = '0; force_reset = 1'b0;
        check("clear_beats_force", {28'd0, triggered, cause[1:0]}, {28'd0, 2'b10, 2'b00});
        check("ch1_cause_kept", {30'd0, cause[3:2]}, 32'd3);

        // ---- disable while tripped ----
        force_reset = 1'b1; step(); force_reset = 1'b0;
        check("reforce_ch0", {30'd0, triggered}, 32'd3);
        enable = 2'b10; step();
        check("disable_clears", {29'd0, triggered[0], cause[1:0]}, 32'd0);
        steps(10);

        // ---- reset in the middle of a pulse ----
        enable = 2'b11; clear_trip = 2'b11; step(); clear_trip = '0;
        force_reset = 1'b1; step(); force_reset = 1'b0;
        steps(3);
        check("pulse_active", {31'd0, sys_rst_req}, 32'd1);
        rst = 1'b1; step();
        check("rst_mid_pulse", {22'd0, warning, triggered, cause, any_triggered, sys_rst_req}, 32'd0);
        step();
        rst = 1'b0; enable = '0; steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
